cgra_net_iface: RTL and testbench

PE-side network interface sitting at the local port of a cgra_router. It is the far end of the router's local port.
- TX path: buffers PE packet requests in a FIFO and injects them one flit per cycle into the router local input, with a programmable idle gap between injections.
- RX path: captures flits ejected by the router into a FIFO and presents them to the PE with valid/ready. The router has no backpressure, so RX overflow drops flits and sets a sticky flag.

---
 rtl/cgra_ni_pkg.sv | 22 ++
 rtl/cgra_ni_fifo.sv | 58 +++++
 rtl/cgra_net_iface.sv | 218 +++++++++++++++++++++
 tb/tb_cgra_net_iface.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cgra_ni_pkg.sv
// cgra_ni_pkg: shared types and constants for the CGRA PE-side network
// interface (cgra_net_iface and its FIFO sub-module).
//   ni_inj_state_e : inject FSM state encoding
//   NI_STAT_WIDTH  : width of the optional statistics counters
//   NI_GAP_WIDTH   : width of the inter-injection gap down-counter
//   ni_sat_inc     : saturating increment for the statistics counters
package cgra_ni_pkg;

  typedef enum logic [1:0] {
    NI_IDLE,
    NI_SEND,
    NI_GAP
  } ni_inj_state_e;

  localparam int NI_STAT_WIDTH = 16;
  localparam int NI_GAP_WIDTH  = 4;

  function automatic logic [NI_STAT_WIDTH-1:0] ni_sat_inc(input logic [NI_STAT_WIDTH-1:0] v);
    return (&v) ? v : v + NI_STAT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/cgra_ni_fifo.sv
// cgra_ni_fifo: synchronous show-ahead FIFO with full/empty flags.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate occupancy counter.
// Ports:
//   clk, rst_n        clock, async active-low reset (flushes pointers)
//   push, push_data   write request / data
//   pop               read request; head advances on the next edge
//   pop_data          current head (valid while !empty)
//   full, empty       status flags
// A push while full is accepted only when a pop happens in the same cycle.
module cgra_ni_fifo
  import cgra_ni_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: a flush resets the pointers, so stale words are unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/cgra_net_iface.sv
// cgra_net_iface: PE-side network interface at the local port of a cgra_router.
//
// state   | meaning
// --------+---------------------------------------------------------------
// NI_IDLE | nothing on the wire; pop TX head as soon as one is queued
// NI_SEND | loc_valid_out high for this single cycle
// NI_GAP  | forced idle between injections; gap_cnt counts down to 0
//
// TX path: PE packets are queued and injected one flit per cycle into the
// router local input, with INJ_GAP idle cycles forced between injections.
// RX path: ejected flits are queued for the PE (valid/ready). The router has
// no backpressure, so an RX flit arriving to a full FIFO that is not being
// drained is dropped and the sticky rx_overflow flag is set.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   pe_tx_*                    PE packet request (valid/ready, data, dest, multicast)
//   loc_*_out, loc_valid_out   to router local input
//   loc_data_in, loc_valid_in  from router local output
//   pe_rx_valid/ready/data     RX head to the PE (show-ahead)
//   tx_empty                   TX FIFO empty and injector idle
//   rx_overflow, rx_overflow_clr  sticky drop flag and its clear (set wins)
// Build option CGRA_NI_STATS_EN adds saturating counters tx_pkt_cnt,
// rx_pkt_cnt and rx_drop_cnt.
module cgra_net_iface
  import cgra_ni_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int TX_DEPTH   = 4,
  parameter int RX_DEPTH   = 4,
  parameter int INJ_GAP    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pe_tx_valid,
  output logic                  pe_tx_ready,
  input  logic [DATA_WIDTH-1:0] pe_tx_data,
  input  logic [ADDR_WIDTH-1:0] pe_tx_dest_x,
  input  logic [ADDR_WIDTH-1:0] pe_tx_dest_y,
  input  logic                  pe_tx_multicast,
  output logic [DATA_WIDTH-1:0] loc_data_out,
  output logic [ADDR_WIDTH-1:0] loc_dest_x_out,
  output logic [ADDR_WIDTH-1:0] loc_dest_y_out,
  output logic                  loc_multicast_out,
  output logic                  loc_valid_out,
  input  logic [DATA_WIDTH-1:0] loc_data_in,
  input  logic                  loc_valid_in,
  output logic                  pe_rx_valid,
  input  logic                  pe_rx_ready,
  output logic [DATA_WIDTH-1:0] pe_rx_data,
  output logic                  tx_empty,
  output logic                  rx_overflow,
`ifdef CGRA_NI_STATS_EN
  input  logic                  rx_overflow_clr,
  output logic [NI_STAT_WIDTH-1:0] tx_pkt_cnt,
  output logic [NI_STAT_WIDTH-1:0] rx_pkt_cnt,
  output logic [NI_STAT_WIDTH-1:0] rx_drop_cnt
`else
  input  logic                  rx_overflow_clr
`endif
);

  localparam int TX_WIDTH = DATA_WIDTH + 2*ADDR_WIDTH + 1;
  localparam logic [NI_GAP_WIDTH-1:0] GAP_LOAD = (INJ_GAP > 0) ? NI_GAP_WIDTH'(INJ_GAP - 1) : '0;
  localparam logic [NI_GAP_WIDTH-1:0] GAP_ONE  = NI_GAP_WIDTH'(1);

  // ---------------- TX ----------------
  logic [TX_WIDTH-1:0]     tx_push_data;
  logic [TX_WIDTH-1:0]     tx_head;
  logic                    tx_fifo_full;
  logic                    tx_fifo_empty;
  logic                    tx_pop;
  logic                    tx_load;
  ni_inj_state_e           state;
  ni_inj_state_e           state_nxt;
  logic [NI_GAP_WIDTH-1:0] gap_cnt;
  logic [NI_GAP_WIDTH-1:0] gap_cnt_nxt;
  logic                    valid_nxt;

  assign pe_tx_ready  = !tx_fifo_full;
  assign tx_push_data = {pe_tx_multicast, pe_tx_dest_y, pe_tx_dest_x, pe_tx_data};
  assign tx_empty     = tx_fifo_empty && (state == NI_IDLE);

  cgra_ni_fifo #(
    .WIDTH (TX_WIDTH),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pe_tx_valid && pe_tx_ready),
    .push_data (tx_push_data),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .full      (tx_fifo_full),
    .empty     (tx_fifo_empty)
  );

  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    tx_pop      = 1'b0;
    tx_load     = 1'b0;
    valid_nxt   = 1'b0;
    case (state)
      NI_IDLE: begin
        if (!tx_fifo_empty) begin
          tx_pop    = 1'b1;
          tx_load   = 1'b1;
          valid_nxt = 1'b1;
          state_nxt = NI_SEND;
        end
      end
      NI_SEND: begin
        if (INJ_GAP == 0) begin
          if (!tx_fifo_empty) begin
            tx_pop    = 1'b1;
            tx_load   = 1'b1;
            valid_nxt = 1'b1;
          end else begin
            state_nxt = NI_IDLE;
          end
        end else begin
          state_nxt   = NI_GAP;
          gap_cnt_nxt = GAP_LOAD;
        end
      end
      NI_GAP: begin
        // Injecting straight out of the last gap cycle keeps the spacing at
        // exactly INJ_GAP idle cycles rather than INJ_GAP plus an IDLE cycle.
        if (gap_cnt == '0) begin
          if (!tx_fifo_empty) begin
            tx_pop    = 1'b1;
            tx_load   = 1'b1;
            valid_nxt = 1'b1;
            state_nxt = NI_SEND;
          end else begin
            state_nxt = NI_IDLE;
          end
        end else begin
          gap_cnt_nxt = gap_cnt - GAP_ONE;
        end
      end
      default: state_nxt = NI_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= NI_IDLE;
      gap_cnt           <= '0;
      loc_valid_out     <= 1'b0;
      loc_data_out      <= '0;
      loc_dest_x_out    <= '0;
      loc_dest_y_out    <= '0;
      loc_multicast_out <= 1'b0;
    end else begin
      state         <= state_nxt;
      gap_cnt       <= gap_cnt_nxt;
      loc_valid_out <= valid_nxt;
      if (tx_load) begin
        {loc_multicast_out, loc_dest_y_out, loc_dest_x_out, loc_data_out} <= tx_head;
      end
    end
  end

  // ---------------- RX ----------------
  logic rx_fifo_full;
  logic rx_fifo_empty;
  logic rx_pop;
  logic rx_drop;
  logic rx_push;

  assign pe_rx_valid = !rx_fifo_empty;
  assign rx_pop      = pe_rx_valid && pe_rx_ready;
  // When full, pe_rx_valid is high, so pe_rx_ready alone decides whether a slot frees up.
  assign rx_drop     = loc_valid_in && rx_fifo_full && !pe_rx_ready;
  assign rx_push     = loc_valid_in && !rx_drop;

  cgra_ni_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rx_push),
    .push_data (loc_data_in),
    .pop       (rx_pop),
    .pop_data  (pe_rx_data),
    .full      (rx_fifo_full),
    .empty     (rx_fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_overflow <= 1'b0;
    end else if (rx_drop) begin
      rx_overflow <= 1'b1;
    end else if (rx_overflow_clr) begin
      rx_overflow <= 1'b0;
    end
  end

`ifdef CGRA_NI_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_pkt_cnt  <= '0;
      rx_pkt_cnt  <= '0;
      rx_drop_cnt <= '0;
    end else begin
      if (loc_valid_out) tx_pkt_cnt  <= ni_sat_inc(tx_pkt_cnt);
      if (rx_push)       rx_pkt_cnt  <= ni_sat_inc(rx_pkt_cnt);
      if (rx_drop)       rx_drop_cnt <= ni_sat_inc(rx_drop_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_cgra_net_iface.sv
// Bench for cgra_net_iface: three instances (INJ_GAP = 0, 2, 3) share one
// stimulus; a queue-based model predicts every output each cycle, and
// directed checks pin the model with hand-computed values.
module tb_cgra_net_iface;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NI = 3;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic pe_tx_valid;
  logic [DW-1:0] pe_tx_data;
  logic [AW-1:0] pe_tx_dest_x, pe_tx_dest_y;
  logic pe_tx_multicast;
  logic [DW-1:0] loc_data_in;
  logic loc_valid_in;
  logic pe_rx_ready;
  logic rx_overflow_clr;

  logic          pe_tx_ready [NI];
  logic [DW-1:0] loc_data_out [NI];
  logic [AW-1:0] loc_dest_x_out [NI];
  logic [AW-1:0] loc_dest_y_out [NI];
  logic          loc_multicast_out [NI];
  logic          loc_valid_out [NI];
  logic          pe_rx_valid [NI];
  logic [DW-1:0] pe_rx_data [NI];
  logic          tx_empty [NI];
  logic          rx_overflow [NI];
`ifdef CGRA_NI_STATS_EN
  logic [15:0] tx_pkt_cnt [NI];
  logic [15:0] rx_pkt_cnt [NI];
  logic [15:0] rx_drop_cnt [NI];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    cgra_net_iface #(
      .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .TX_DEPTH (DEPTH), .RX_DEPTH (DEPTH),
      .INJ_GAP    (g == 0 ? 0 : (g == 1 ? 2 : 3))
    ) u_dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .pe_tx_valid       (pe_tx_valid),
      .pe_tx_ready       (pe_tx_ready[g]),
      .pe_tx_data        (pe_tx_data),
      .pe_tx_dest_x      (pe_tx_dest_x),
      .pe_tx_dest_y      (pe_tx_dest_y),
      .pe_tx_multicast   (pe_tx_multicast),
      .loc_data_out      (loc_data_out[g]),
      .loc_dest_x_out    (loc_dest_x_out[g]),
      .loc_dest_y_out    (loc_dest_y_out[g]),
      .loc_multicast_out (loc_multicast_out[g]),
      .loc_valid_out     (loc_valid_out[g]),
      .loc_data_in       (loc_data_in),
      .loc_valid_in      (loc_valid_in),
      .pe_rx_valid       (pe_rx_valid[g]),
      .pe_rx_ready       (pe_rx_ready),
      .pe_rx_data        (pe_rx_data[g]),
      .tx_empty          (tx_empty[g]),
      .rx_overflow       (rx_overflow[g]),
`ifdef CGRA_NI_STATS_EN
      .tx_pkt_cnt        (tx_pkt_cnt[g]),
      .rx_pkt_cnt        (rx_pkt_cnt[g]),
      .rx_drop_cnt       (rx_drop_cnt[g]),
`endif
      .rx_overflow_clr   (rx_overflow_clr)
    );
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int gap_of(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 2 : 3);
  endfunction

  // ---------------- model ----------------
  // Rule: a TX injection happens at an edge when the queue (as it stood before
  // the edge) is non-empty and more than INJ_GAP edges have passed since the
  // previous injection. Acceptance of a PE word depends on pre-edge occupancy.
  logic [24:0]   mq [NI][8];
  int            mhead [NI];
  int            mcnt [NI];
  int            last_inj [NI];
  logic [24:0]   exp_loc [NI];
  logic          exp_valid [NI];
  logic [DW-1:0] rq [$];
  logic          exp_ovf;
  int            cyc = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        mhead[i] = 0; mcnt[i] = 0; last_inj[i] = -1000;
        exp_loc[i] = '0; exp_valid[i] = 1'b0;
      end
      rq.delete();
      exp_ovf = 1'b0;
    end else begin
      bit acc, pop, drop;
      cyc++;
      for (int i = 0; i < NI; i++) begin
        acc = pe_tx_valid && (mcnt[i] < DEPTH);
        if (mcnt[i] > 0 && (cyc - last_inj[i]) > gap_of(i)) begin
          exp_loc[i]   = mq[i][mhead[i]];
          mhead[i]     = (mhead[i] + 1) % 8;
          mcnt[i]--;
          last_inj[i]  = cyc;
          exp_valid[i] = 1'b1;
        end else begin
          exp_valid[i] = 1'b0;
        end
        if (acc) begin
          mq[i][(mhead[i] + mcnt[i]) % 8] = {pe_tx_multicast, pe_tx_dest_y, pe_tx_dest_x, pe_tx_data};
          mcnt[i]++;
        end
      end
      pop  = (rq.size() > 0) && pe_rx_ready;
      drop = 1'b0;
      if (pop) void'(rq.pop_front());
      if (loc_valid_in) begin
        if (rq.size() < DEPTH) rq.push_back(loc_data_in);
        else drop = 1'b1;
      end
      if (drop) exp_ovf = 1'b1;
      else if (rx_overflow_clr) exp_ovf = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("m_valid%0d", i), 32'(loc_valid_out[i]), 32'(exp_valid[i]));
        chk($sformatf("m_loc%0d", i),
            32'({loc_multicast_out[i], loc_dest_y_out[i], loc_dest_x_out[i], loc_data_out[i]}),
            32'(exp_loc[i]));
        chk($sformatf("m_ready%0d", i), 32'(pe_tx_ready[i]), 32'(mcnt[i] < DEPTH));
        chk($sformatf("m_txempty%0d", i), 32'(tx_empty[i]),
            32'(mcnt[i] == 0 && (cyc - last_inj[i]) > gap_of(i)));
        chk($sformatf("m_rxvalid%0d", i), 32'(pe_rx_valid[i]), 32'(rq.size() > 0));
        if (rq.size() > 0) chk($sformatf("m_rxdata%0d", i), 32'(pe_rx_data[i]), 32'(rq[0]));
        chk($sformatf("m_ovf%0d", i), 32'(rx_overflow[i]), 32'(exp_ovf));
      end
    end
  end

  // ---------------- capture ----------------
  logic [DW-1:0] cap2_d [$];
  int            cap2_c [$];
  logic [DW-1:0] cap3_d [$];
  int            nvalid = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (loc_valid_out[1]) begin cap2_d.push_back(loc_data_out[1]); cap2_c.push_back(cyc); end
      if (loc_valid_out[2]) cap3_d.push_back(loc_data_out[2]);
      for (int i = 0; i < NI; i++) if (loc_valid_out[i]) nvalid++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_tx(input logic v, input logic [DW-1:0] d, input logic [AW-1:0] x,
                        input logic [AW-1:0] y, input logic m);
    pe_tx_valid = v; pe_tx_data = d; pe_tx_dest_x = x; pe_tx_dest_y = y; pe_tx_multicast = m;
  endtask

  initial begin
    int guard;
    bit seen_full;
    rst_n = 1'b0;
    set_tx(1'b0, '0, '0, '0, 1'b0);
    loc_data_in = '0; loc_valid_in = 1'b0; pe_rx_ready = 1'b0; rx_overflow_clr = 1'b0;
    idle(3);
    rst_n = 1'b1;
    for (int i = 0; i < NI; i++) begin
      chk("rst_ready", 32'(pe_tx_ready[i]), 32'd1);
      chk("rst_txempty", 32'(tx_empty[i]), 32'd1);
      chk("rst_valid", 32'(loc_valid_out[i]), 32'd0);
      chk("rst_data", 32'(loc_data_out[i]), 32'd0);
      chk("rst_rxvalid", 32'(pe_rx_valid[i]), 32'd0);
      chk("rst_ovf", 32'(rx_overflow[i]), 32'd0);
    end

    // 1: single unicast injection latency
    set_tx(1'b1, 16'hABCD, 4'd3, 4'd1, 1'b0);
    @(negedge clk);
    pe_tx_valid = 1'b0;
    chk("t1_not_yet", 32'(loc_valid_out[0]), 32'd0);
    @(negedge clk);
    chk("t1_valid", 32'(loc_valid_out[0]), 32'd1);
    chk("t1_data", 32'(loc_data_out[0]), 32'hABCD);
    chk("t1_dx", 32'(loc_dest_x_out[0]), 32'd3);
    chk("t1_dy", 32'(loc_dest_y_out[0]), 32'd1);
    @(negedge clk);
    chk("t1_one_cycle", 32'(loc_valid_out[0]), 32'd0);
    chk("t1_txempty", 32'(tx_empty[0]), 32'd1);
    idle(8);

    // 2: INJ_GAP=2 spacing
    cap2_d.delete(); cap2_c.delete();
    for (int j = 0; j < 3; j++) begin
      set_tx(1'b1, 16'hA001 + 16'(j), 4'd2, 4'd2, 1'b0);
      @(negedge clk);
    end
    pe_tx_valid = 1'b0;
    idle(15);
    chk("t2_count", 32'(cap2_d.size()), 32'd3);
    for (int j = 0; j < 3 && j < cap2_d.size(); j++)
      chk("t2_order", 32'(cap2_d[j]), 32'hA001 + 32'(j));
    for (int j = 1; j < 3 && j < cap2_c.size(); j++)
      chk("t2_spacing", 32'(cap2_c[j] - cap2_c[j-1]), 32'd3);

    // 3: INJ_GAP=3 with FIFO filling up
    cap3_d.delete();
    seen_full = 1'b0;
    for (int w = 0; w < 6; w++) begin
      set_tx(1'b1, 16'hB001 + 16'(w), 4'd1, 4'd0, 1'b0);
      guard = 0;
      while (!pe_tx_ready[2] && guard < 20) begin
        seen_full = 1'b1;
        @(negedge clk);
        guard++;
      end
      if (guard >= 20) begin
        n_checks++; n_errors++;
        $display("FAIL t3_ready_timeout: pe_tx_ready stuck 0 for word %0d", w);
      end
      @(negedge clk);
    end
    pe_tx_valid = 1'b0;
    idle(40);
    chk("t3_ready_dropped", 32'(seen_full), 32'd1);
    chk("t3_count", 32'(cap3_d.size()), 32'd6);
    for (int j = 0; j < 6 && j < cap3_d.size(); j++)
      chk("t3_order", 32'(cap3_d[j]), 32'hB001 + 32'(j));

    // 4: RX overflow, drain, clear, and full+pop+push boundary
    loc_valid_in = 1'b1;
    for (int j = 0; j < 5; j++) begin
      loc_data_in = 16'h5678 + 16'(j);
      @(negedge clk);
    end
    loc_valid_in = 1'b0;
    chk("t4_ovf_set", 32'(rx_overflow[0]), 32'd1);
    pe_rx_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("t4_drain", 32'(pe_rx_data[0]), 32'h5678 + 32'(j));
      @(negedge clk);
    end
    pe_rx_ready = 1'b0;
    chk("t4_empty", 32'(pe_rx_valid[0]), 32'd0);
    rx_overflow_clr = 1'b1;
    @(negedge clk);
    rx_overflow_clr = 1'b0;
    chk("t4_ovf_clr", 32'(rx_overflow[0]), 32'd0);
    loc_valid_in = 1'b1;
    for (int j = 0; j < 4; j++) begin
      loc_data_in = 16'h6000 + 16'(j);
      @(negedge clk);
    end
    loc_data_in = 16'h6004; pe_rx_ready = 1'b1;
    @(negedge clk);
    pe_rx_ready = 1'b0;
    chk("t4_full_pp_noovf", 32'(rx_overflow[0]), 32'd0);
    chk("t4_full_pp_head", 32'(pe_rx_data[0]), 32'h6001);
    loc_data_in = 16'h6005; rx_overflow_clr = 1'b1;
    @(negedge clk);
    loc_valid_in = 1'b0; rx_overflow_clr = 1'b0;
    chk("t4_set_wins", 32'(rx_overflow[0]), 32'd1);
    pe_rx_ready = 1'b1;
    idle(4);
    pe_rx_ready = 1'b0;
    rx_overflow_clr = 1'b1;
    @(negedge clk);
    rx_overflow_clr = 1'b0;
    idle(2);

    // 5: multicast flag
    set_tx(1'b1, 16'hFFFF, 4'd0, 4'd0, 1'b1);
    @(negedge clk);
    set_tx(1'b0, '0, '0, '0, 1'b0);
    @(negedge clk);
    chk("t5_valid", 32'(loc_valid_out[0]), 32'd1);
    chk("t5_mc", 32'(loc_multicast_out[0]), 32'd1);
    chk("t5_data", 32'(loc_data_out[0]), 32'hFFFF);
    idle(8);

    // 6: asynchronous reset mid-injection
    for (int j = 0; j < 4; j++) begin
      set_tx(1'b1, 16'hC001 + 16'(j), 4'd5, 4'd6, 1'b0);
      loc_valid_in = (j < 2); loc_data_in = 16'h7000 + 16'(j);
      @(negedge clk);
    end
    set_tx(1'b0, '0, '0, '0, 1'b0);
    loc_valid_in = 1'b0;
    @(negedge clk);
    chk("t6_pre_valid", 32'(loc_valid_out[1]), 32'd1);
    chk("t6_pre_data", 32'(loc_data_out[1]), 32'hC002);
    chk("t6_pre_rx", 32'(pe_rx_valid[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) chk("t6_async_drop", 32'(loc_valid_out[i]), 32'd0);
    idle(2);
    rst_n = 1'b1;
    for (int i = 0; i < NI; i++) begin
      chk("t6_txempty", 32'(tx_empty[i]), 32'd1);
      chk("t6_rxvalid", 32'(pe_rx_valid[i]), 32'd0);
    end
    nvalid = 0;
    idle(12);
    chk("t6_no_inject", 32'(nvalid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
